mc_datapath: RTL
================

// Module: mc_datapath
// PURPOSE
//  Multi-cycle successor to the single-cycle RV32I datapath: one shared memory port with a req/ready handshake.
//  An internal step sequencer (FETCH/DECODE/EXEC/MEM/WB) replaces separate instruction and data memories.
//  Sits between the existing combinational decoder, which drives the control inputs from Instr, and a single
//  unified memory/bus.
//  Reuses regfile, alu, extend, stextend, ldextend and cmp.
//  Generalised in register count (RV32I/RV32E) and reset vector.
// PARAMETERS
//  XLEN      32             datapath width; all PC/ALU/memory widths
//  NREGS     32             architectural registers, 32 (I) or 16 (E); reg index bits = $clog2(NREGS)
//  RESET_PC  32'h0000_0000  PC value loaded on reset
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     asynchronous, active-low reset
//  ResultSrc   in   3     WB select: 0 ALU, 1 load, 2 PC+4, 3 branch flag, 4 imm, 5 PC+imm
//  PCSrc       in   2     0 PC+4, 1 PC+imm, 2/3 ALU result (jalr)
//  RegWrite    in   1     write rd in WB
//  MemWrite    in   1     instruction is a store
//  ALUSrc      in   1     SrcB: 0 rs2, 1 imm
//  ImmSrc      in   3     immediate format
//  ALUControl  in   3     ALU op
//  branch_op   in   3     compare op
//  memwritefrmt in  2     store size (b/h/w)
//  ld_op       in   3     load size/sign
//  Instr       out  XLEN  instruction register (IR) contents, feeds decoder
//  Branch_En   out  1     latched compare result of current instruction
//  PC          out  XLEN  PC of instruction in flight
//  mem_req     out  1     memory request valid
//  mem_we      out  1     1 = write
//  mem_addr    out  XLEN  byte address
//  mem_wdata   out  XLEN  write data (stextend output)
//  mem_rdata   in   XLEN  read data, valid when mem_ready & ~mem_we
//  mem_ready   in   1     transfer completes on a cycle where mem_req & mem_ready
// BEHAVIOUR
//  Reset (async, rst=0):
//   - state=FETCH; PC=RESET_PC; Instr=32'h0000_0013 (nop); Branch_En=0.
//   - mem_req=0, mem_we=0, mem_addr=RESET_PC, mem_wdata=0.
//   - Internal A/B/ALUOut/MDR clear to 0. Regfile contents not reset.
//   - A reset mid-transfer drops mem_req immediately; a pending ready is ignored.
//  FETCH:  mem_req=1, mem_we=0, mem_addr=PC. On ready: IR<=mem_rdata, ->DECODE. Zero-wait (ready in first cycle) legal.
//  DECODE: decoder settles on new IR. A<=rf[rs1], B<=rf[rs2], Imm latched. ->EXEC.
//  EXEC:   ALUOut<=alu(A, ALUSrc?Imm:B); Branch_En<=cmp(A,B). ->MEM if load or store (ResultSrc==1 | MemWrite), else ->WB.
//  MEM:
//   - mem_req=1, mem_addr=ALUOut, mem_we=MemWrite, mem_wdata=stextend(B).
//   - On ready: load latches MDR<=mem_rdata. ->WB.
//  WB:
//   - If RegWrite, rf[rd]<=mux(ResultSrc); load data via ldextend(MDR); writes to x0 discarded.
//   - PC<=PCSrc select, using PC+4 / PC+Imm / ALUOut. ->FETCH.
//  Handshake:
//   - mem_addr/mem_we/mem_wdata held stable while mem_req=1 and ready=0.
//   - mem_req drops in the cycle after the accepting edge.
//   - mem_ready while mem_req=0 is ignored.
//  Latency (zero-wait memory): ALU/branch/jump 4 cycles; load/store 5 cycles. Each wait cycle adds 1.
//  Arithmetic: PC+4 and PC+Imm wrap modulo 2^XLEN. rd/rs index >= NREGS reads 0; write ignored.
//  Register sources are captured in DECODE, so WB-to-next-instruction forwarding is never needed.
// STRUCTURE
//  Package mc_pkg:
//   - step_t enum {FETCH, DECODE, EXEC, MEM, WB}
//   - ResultSrc/PCSrc encodings as localparams
//   - NOP_INSTR
//  One sub-module: mc_seq. Holds the state register and next-state logic; outputs per-state enables
//  (ir_en, ab_en, aluout_en, mdr_en, rf_we, pc_en, mem_req).
//  Datapath registers and muxes stay in mc_datapath.
// TESTING
//  1 Reset with RESET_PC=32'h100
//    -> PC=0x100, mem_req=0 during reset
//    -> first request addr 0x100 one cycle after rst deasserts
//  2 addi x1,x0,5 with zero-wait memory
//    -> x1=5 after exactly 4 cycles; PC=0x104; next FETCH addr 0x104
//  3 sw x1,8(x0), ready held low 3 cycles
//    -> addr 0x8, we=1, wdata=5 held stable across the stall; store completes in 8 cycles
//  4 lb x2,8(x0) with mem byte 0x80
//    -> x2=0xFFFF_FF80
//  5 beq taken at PC=0xFFFF_FFFC, imm=+8 -> PC=0x0000_0004 (wrap)
//    jal x0 -> x0 stays 0
//  6 rst asserted mid-MEM stall -> mem_req=0 immediately; restart fetches from RESET_PC
//    NREGS=16: write x20 ignored, read x20 returns 0

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I datapath and its step sequencer.
package mc_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} step_t;

  // write-back source select
  localparam logic [2:0] RES_ALU   = 3'd0;
  localparam logic [2:0] RES_LOAD  = 3'd1;
  localparam logic [2:0] RES_PC4   = 3'd2;
  localparam logic [2:0] RES_BR    = 3'd3;
  localparam logic [2:0] RES_IMM   = 3'd4;
  localparam logic [2:0] RES_PCIMM = 3'd5;

  // next-PC select (2 and 3 both take the ALU result, used by jalr)
  localparam logic [1:0] PCS_PLUS4 = 2'd0;
  localparam logic [1:0] PCS_IMM   = 2'd1;

  // immediate formats
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLT = 3'd5;
  localparam logic [2:0] ALU_SLL = 3'd6;
  localparam logic [2:0] ALU_SRL = 3'd7;

  // compare ops follow branch funct3
  localparam logic [2:0] BR_EQ  = 3'd0;
  localparam logic [2:0] BR_NE  = 3'd1;
  localparam logic [2:0] BR_LT  = 3'd4;
  localparam logic [2:0] BR_GE  = 3'd5;
  localparam logic [2:0] BR_LTU = 3'd6;
  localparam logic [2:0] BR_GEU = 3'd7;

  // store sizes
  localparam logic [1:0] ST_B = 2'd0;
  localparam logic [1:0] ST_H = 2'd1;

  // load size/sign follow load funct3
  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_HU = 3'd5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mc_seq.sv
// Step sequencer: FETCH/DECODE/EXEC/MEM/WB state and per-step register enables.
module mc_seq
  import mc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mem_ready,
  input  logic reg_write,
  input  logic mem_write,
  input  logic mem_read,
  output logic ir_en,
  output logic ab_en,
  output logic aluout_en,
  output logic mdr_en,
  output logic rf_we,
  output logic pc_en,
  output logic mem_req,
  output logic mem_sel
);

  step_t state, nxt;
  logic  run;  // holds off the first fetch request until one edge after reset release

  // state register; reset parks in FETCH with requests gated off
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      run   <= 1'b0;
    end else begin
      state <= nxt;
      run   <= 1'b1;
    end
  end

  // next-step and per-step enables
  always_comb begin
    nxt       = state;
    ir_en     = 1'b0;
    ab_en     = 1'b0;
    aluout_en = 1'b0;
    mdr_en    = 1'b0;
    rf_we     = 1'b0;
    pc_en     = 1'b0;
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    case (state)
      FETCH: begin
        mem_req = run;
        if (run && mem_ready) begin
          ir_en = 1'b1;
          nxt   = DECODE;
        end
      end
      DECODE: begin
        ab_en = 1'b1;
        nxt   = EXEC;
      end
      EXEC: begin
        aluout_en = 1'b1;
        nxt       = (mem_read || mem_write) ? MEM : WB;
      end
      MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        if (mem_ready) begin
          mdr_en = mem_read;
          nxt    = WB;
        end
      end
      WB: begin
        rf_we = reg_write;
        pc_en = 1'b1;
        nxt   = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle RV32I datapath on one shared req/ready memory port.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      ResultSrc,
  input  logic [1:0]      PCSrc,
  input  logic            RegWrite,
  input  logic            MemWrite,
  input  logic            ALUSrc,
  input  logic [2:0]      ImmSrc,
  input  logic [2:0]      ALUControl,
  input  logic [2:0]      branch_op,
  input  logic [1:0]      memwritefrmt,
  input  logic [2:0]      ld_op,
  output logic [XLEN-1:0] Instr,
  output logic            Branch_En,
  output logic [XLEN-1:0] PC,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  localparam int RW = $clog2(NREGS);
  localparam int SH = $clog2(XLEN);

  logic [XLEN-1:0] a_q, b_q, imm_q, aluout_q, mdr_q;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_d, srcb, alu_y, ld_ext, result, pc_next;
  logic [XLEN-1:0] rf [NREGS];
  logic [4:0]      rs1, rs2, rd;
  logic            br, ir_en, ab_en, aluout_en, mdr_en, rf_we, pc_en, mem_sel;

  assign rs1 = Instr[19:15];
  assign rs2 = Instr[24:20];
  assign rd  = Instr[11:7];

  mc_seq u_seq (
    .clk       (clk),
    .rst       (rst),
    .mem_ready (mem_ready),
    .reg_write (RegWrite),
    .mem_write (MemWrite),
    .mem_read  (ResultSrc == RES_LOAD),
    .ir_en     (ir_en),
    .ab_en     (ab_en),
    .aluout_en (aluout_en),
    .mdr_en    (mdr_en),
    .rf_we     (rf_we),
    .pc_en     (pc_en),
    .mem_req   (mem_req),
    .mem_sel   (mem_sel)
  );

  // register file read: x0 and indices beyond NREGS read as zero
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (rs1 != 5'd0 && int'(rs1) < NREGS) rs1_val = rf[rs1[RW-1:0]];
    if (rs2 != 5'd0 && int'(rs2) < NREGS) rs2_val = rf[rs2[RW-1:0]];
  end

  // register file write in WB; x0 and out-of-range rd are dropped
  always_ff @(posedge clk) begin
    if (rf_we && rd != 5'd0 && int'(rd) < NREGS) rf[rd[RW-1:0]] <= result;
  end

  // immediate generation from the instruction register
  always_comb begin
    imm_d = '0;
    case (ImmSrc)
      IMM_I: imm_d = {{(XLEN-12){Instr[31]}}, Instr[31:20]};
      IMM_S: imm_d = {{(XLEN-12){Instr[31]}}, Instr[31:25], Instr[11:7]};
      IMM_B: imm_d = {{(XLEN-12){Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
      IMM_J: imm_d = {{(XLEN-20){Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};
      IMM_U: imm_d = XLEN'($signed({Instr[31:12], 12'b0}));
      default: imm_d = '0;
    endcase
  end

  assign srcb = ALUSrc ? imm_q : b_q;

  // ALU
  always_comb begin
    alu_y = '0;
    case (ALUControl)
      ALU_ADD: alu_y = a_q + srcb;
      ALU_SUB: alu_y = a_q - srcb;
      ALU_AND: alu_y = a_q & srcb;
      ALU_OR:  alu_y = a_q | srcb;
      ALU_XOR: alu_y = a_q ^ srcb;
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(srcb)};
      ALU_SLL: alu_y = a_q << srcb[SH-1:0];
      ALU_SRL: alu_y = a_q >> srcb[SH-1:0];
      default: alu_y = '0;
    endcase
  end

  // branch compare on the latched register operands
  always_comb begin
    br = 1'b0;
    case (branch_op)
      BR_EQ:   br = (a_q == b_q);
      BR_NE:   br = (a_q != b_q);
      BR_LT:   br = ($signed(a_q) <  $signed(b_q));
      BR_GE:   br = ($signed(a_q) >= $signed(b_q));
      BR_LTU:  br = (a_q <  b_q);
      BR_GEU:  br = (a_q >= b_q);
      default: br = 1'b0;
    endcase
  end

  // store data: narrow stores present the value zero-extended in the low lane
  always_comb begin
    mem_wdata = b_q;
    case (memwritefrmt)
      ST_B:    mem_wdata = {{(XLEN-8){1'b0}}, b_q[7:0]};
      ST_H:    mem_wdata = {{(XLEN-16){1'b0}}, b_q[15:0]};
      default: mem_wdata = b_q;
    endcase
  end

  // load data: the bus returns the addressed item in the low lane
  always_comb begin
    ld_ext = mdr_q;
    case (ld_op)
      LD_B:    ld_ext = {{(XLEN-8){mdr_q[7]}}, mdr_q[7:0]};
      LD_H:    ld_ext = {{(XLEN-16){mdr_q[15]}}, mdr_q[15:0]};
      LD_BU:   ld_ext = {{(XLEN-8){1'b0}}, mdr_q[7:0]};
      LD_HU:   ld_ext = {{(XLEN-16){1'b0}}, mdr_q[15:0]};
      default: ld_ext = mdr_q;
    endcase
  end

  // write-back select and next PC (adds wrap modulo 2^XLEN)
  always_comb begin
    result = aluout_q;
    case (ResultSrc)
      RES_LOAD:  result = ld_ext;
      RES_PC4:   result = PC + XLEN'(4);
      RES_BR:    result = {{(XLEN-1){1'b0}}, Branch_En};
      RES_IMM:   result = imm_q;
      RES_PCIMM: result = PC + imm_q;
      default:   result = aluout_q;
    endcase
    case (PCSrc)
      PCS_PLUS4: pc_next = PC + XLEN'(4);
      PCS_IMM:   pc_next = PC + imm_q;
      default:   pc_next = aluout_q;
    endcase
  end

  assign mem_addr = mem_sel ? aluout_q : PC;
  assign mem_we   = mem_sel & MemWrite;

  // architectural and inter-step registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC        <= RESET_PC;
      Instr     <= XLEN'(NOP_INSTR);
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      aluout_q  <= '0;
      mdr_q     <= '0;
      Branch_En <= 1'b0;
    end else begin
      if (ir_en) Instr <= mem_rdata;
      if (ab_en) begin
        a_q   <= rs1_val;
        b_q   <= rs2_val;
        imm_q <= imm_d;
      end
      if (aluout_en) begin
        aluout_q  <= alu_y;
        Branch_En <= br;
      end
      if (mdr_en) mdr_q <= mem_rdata;
      if (pc_en)  PC    <= pc_next;
    end
  end

endmodule
